// File: rtl/keccak_ctrl_pkg.sv
// ============================================================================
// keccak_ctrl_pkg : shared FSM states, sizes and helpers for keccak_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

package keccak_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_CORE_RST  = 3'd0,
    ST_COLLECT   = 3'd1,
    ST_PUSH      = 3'd2,
    ST_PUSH_LAST = 3'd3,
    ST_WAIT_HASH = 3'd4,
    ST_SEND      = 3'd5
  } state_e;

  localparam int         DIGEST_BYTES = 64;
  localparam int         WORD_BYTES   = 4;
  localparam logic [7:0] HEX_LF       = 8'h0A;

  // Lowercase ASCII hex digit for one nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
  endfunction

endpackage

`default_nettype wire

// File: rtl/keccak_ctrl_if.sv
// ============================================================================
// keccak_ctrl_if : UART-side, core-side and TX handshake bundle of keccak_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

interface keccak_ctrl_if;

  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_last;
  logic         rx_empty_msg;
  logic         rx_ready;
  logic         k_reset;
  logic [31:0]  k_in;
  logic         k_in_ready;
  logic         k_is_last;
  logic [1:0]   k_byte_num;
  logic         k_buffer_full;
  logic [511:0] k_out;
  logic         k_out_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;

  modport master (
    input  rx_data, rx_valid, rx_last, rx_empty_msg,
    output rx_ready,
    output k_reset, k_in, k_in_ready, k_is_last, k_byte_num,
    input  k_buffer_full, k_out, k_out_ready,
    output tx_data, tx_valid,
    input  tx_ready,
    output busy
  );

  modport slave (
    output rx_data, rx_valid, rx_last, rx_empty_msg,
    input  rx_ready,
    input  k_reset, k_in, k_in_ready, k_is_last, k_byte_num,
    output k_buffer_full, k_out, k_out_ready,
    input  tx_data, tx_valid,
    output tx_ready,
    input  busy
  );

endinterface

`default_nettype wire

// File: rtl/keccak_word_packer.sv
// ============================================================================
// keccak_word_packer : left-justified byte-to-word packer with mod-4 count
// Rev 1.0
// ============================================================================
`default_nettype none

module keccak_word_packer
  import keccak_ctrl_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        clr_i,
  input  wire logic        shift_i,
  input  wire logic [7:0]  byte_i,
  output logic      [31:0] word_o,
  output logic             full_o,
  output logic      [1:0]  byte_num_o
);

  logic [31:0] word_q, word_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [4:0]  w_pos;

  assign w_pos = 5'd31 - {cnt_q, 3'b000};

  // The first byte of a word wipes the previous word, so a partial final
  // word always comes out zero-padded in its low bytes.
  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (shift_i) begin
      if (cnt_q == 2'd0) begin
        word_d = {byte_i, 24'h000000};
      end else begin
        word_d[w_pos -: 8] = byte_i;
      end
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= 32'h0;
      cnt_q  <= 2'd0;
    end else if (clr_i) begin
      word_q <= 32'h0;
      cnt_q  <= 2'd0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o     = word_d;
  assign full_o     = shift_i && (cnt_q == 2'(WORD_BYTES - 1));
  assign byte_num_o = cnt_d;

endmodule

`default_nettype wire

// File: rtl/keccak_ctrl.sv
// ============================================================================
// keccak_ctrl : UART <-> keccak core sequencer (pack, push, wait, stream digest)
// Optional: KECCAK_CTRL_HEX_OUT_EN streams the digest as ASCII hex plus LF.
// Rev 1.0
// ============================================================================
`default_nettype none

module keccak_ctrl
  import keccak_ctrl_pkg::*;
#(
  parameter int CORE_RST_CYCLES = 2
)(
  input wire logic      clk,
  input wire logic      rst_n,
  keccak_ctrl_if.master bus
);

`ifdef KECCAK_CTRL_HEX_OUT_EN
  localparam logic [7:0] TX_LAST = 8'(2 * DIGEST_BYTES);
`else
  localparam logic [7:0] TX_LAST = 8'(DIGEST_BYTES - 1);
`endif
  localparam logic [3:0] RST_LAST = 4'(CORE_RST_CYCLES - 1);

  function automatic logic [7:0] tx_byte(input logic [511:0] d, input logic [7:0] i);
    logic [8:0] base;
`ifdef KECCAK_CTRL_HEX_OUT_EN
    base = 9'd511 - 9'({i, 2'b00});
    if (i == TX_LAST) return HEX_LF;
    return hex_char(d[base -: 4]);
`else
    base = 9'd511 - 9'({i, 3'b000});
    return d[base -: 8];
`endif
  endfunction

  state_e      state_q;
  logic [3:0]  rst_cnt_q;
  logic        k_reset_q;
  logic        rx_ready_q;
  logic        busy_q;
  logic [31:0] k_in_q;
  logic [1:0]  byte_num_q;
  logic        pend_last_q;
  logic [7:0]  tx_data_q;
  logic        tx_valid_q;
  logic [7:0]  tx_idx_q;

  logic        w_shift;
  logic [31:0] w_word;
  logic        w_full;
  logic [1:0]  w_byte_num;
  logic        w_push;

  assign w_shift = rx_ready_q && bus.rx_valid;

  keccak_word_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (k_reset_q),
    .shift_i    (w_shift),
    .byte_i     (bus.rx_data),
    .word_o     (w_word),
    .full_o     (w_full),
    .byte_num_o (w_byte_num)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_CORE_RST;
      rst_cnt_q   <= 4'd0;
      k_reset_q   <= 1'b1;
      rx_ready_q  <= 1'b0;
      busy_q      <= 1'b1;
      k_in_q      <= 32'h0;
      byte_num_q  <= 2'd0;
      pend_last_q <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      tx_idx_q    <= 8'd0;
    end else begin
      case (state_q)
        ST_CORE_RST: begin
          k_in_q      <= 32'h0;
          byte_num_q  <= 2'd0;
          pend_last_q <= 1'b0;
          tx_idx_q    <= 8'd0;
          if (rst_cnt_q == RST_LAST) begin
            rst_cnt_q  <= 4'd0;
            k_reset_q  <= 1'b0;
            rx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= ST_COLLECT;
          end else begin
            rst_cnt_q <= rst_cnt_q + 4'd1;
          end
        end

        ST_COLLECT: begin
          // A data byte outranks a coincident empty-message pulse.
          if (bus.rx_valid) begin
            if (bus.rx_last || w_full) begin
              rx_ready_q <= 1'b0;
              busy_q     <= 1'b1;
              k_in_q     <= w_word;
              if (bus.rx_last && (w_byte_num != 2'd0)) begin
                byte_num_q <= w_byte_num;
                state_q    <= ST_PUSH_LAST;
              end else begin
                byte_num_q  <= 2'd0;
                pend_last_q <= bus.rx_last;
                state_q     <= ST_PUSH;
              end
            end
          end else if (bus.rx_empty_msg) begin
            rx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            k_in_q     <= 32'h0;
            byte_num_q <= 2'd0;
            state_q    <= ST_PUSH_LAST;
          end
        end

        ST_PUSH: begin
          if (!bus.k_buffer_full) begin
            // Length was a multiple of 4: close with an empty final word.
            if (pend_last_q) begin
              pend_last_q <= 1'b0;
              k_in_q      <= 32'h0;
              byte_num_q  <= 2'd0;
              state_q     <= ST_PUSH_LAST;
            end else begin
              rx_ready_q <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= ST_COLLECT;
            end
          end
        end

        ST_PUSH_LAST: begin
          if (!bus.k_buffer_full) begin
            state_q <= ST_WAIT_HASH;
          end
        end

        ST_WAIT_HASH: begin
          if (bus.k_out_ready) begin
            tx_data_q  <= tx_byte(bus.k_out, 8'd0);
            tx_valid_q <= 1'b1;
            tx_idx_q   <= 8'd0;
            state_q    <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (bus.tx_ready) begin
            if (tx_idx_q == TX_LAST) begin
              tx_valid_q <= 1'b0;
              k_reset_q  <= 1'b1;
              rst_cnt_q  <= 4'd0;
              state_q    <= ST_CORE_RST;
            end else begin
              tx_idx_q  <= tx_idx_q + 8'd1;
              tx_data_q <= tx_byte(bus.k_out, tx_idx_q + 8'd1);
            end
          end
        end

        default: begin
          k_reset_q <= 1'b1;
          rst_cnt_q <= 4'd0;
          state_q   <= ST_CORE_RST;
        end
      endcase
    end
  end

  // Qualified by buffer_full in the same cycle so a word is taken exactly once.
  assign w_push = (state_q == ST_PUSH) || (state_q == ST_PUSH_LAST);

  assign bus.rx_ready   = rx_ready_q;
  assign bus.k_reset    = k_reset_q;
  assign bus.k_in       = k_in_q;
  assign bus.k_in_ready = w_push && !bus.k_buffer_full;
  assign bus.k_is_last  = (state_q == ST_PUSH_LAST) && !bus.k_buffer_full;
  assign bus.k_byte_num = byte_num_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.busy       = busy_q;

endmodule

`default_nettype wire

// File: doc/keccak_ctrl.md
Name: keccak_ctrl

Overview:
Sequencer between the byte-serial UART front end and the keccak hash core (32-bit word input, 512-bit digest).
- Packs received message bytes into 32-bit words.
- Drives the core's in / in_ready / is_last / byte_num handshake and resets the core before every message.
- Waits for the digest, then streams it byte-serially to the UART transmitter.
- One message in flight at a time.

Parameters:
- CORE_RST_CYCLES, 2: cycles k_reset is held high before each message; legal range 1..15.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  message byte from UART RX
- rx_valid  in  1  rx_data valid this cycle
- rx_last  in  1  qualifies rx_valid; byte is the final message byte
- rx_empty_msg  in  1  one-cycle pulse: zero-length message (no data bytes)
- rx_ready  out  1  controller accepts a byte/empty_msg this cycle
- k_reset  out  1  synchronous active-high reset to the keccak core
- k_in  out  32  word to core; first byte in [31:24]
- k_in_ready  out  1  word valid to core
- k_is_last  out  1  final word of message
- k_byte_num  out  2  valid bytes in final word (0..3)
- k_buffer_full  in  1  core cannot accept a word
- k_out  in  512  digest; byte 0 = k_out[511:504]
- k_out_ready  in  1  digest valid (sticky until k_reset)
- tx_data  out  8  digest byte to UART TX
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX accepts tx_data
- busy  out  1  high in every state except COLLECT

Behaviour:
- Reset values: rx_ready 0, k_reset 1, k_in 0, k_in_ready 0, k_is_last 0, k_byte_num 0, tx_data 0, tx_valid 0, busy 1. After rst_n is released, the FSM enters CORE_RST.
- CORE_RST:
  - k_reset=1 for CORE_RST_CYCLES cycles, then COLLECT.
  - Byte counter, word register and digest index are cleared.
- COLLECT:
  - rx_ready=1. An rx_valid byte is shifted into the word register (MSB-first); the byte count mod 4 increments.
  - 4th byte without rx_last: go to PUSH with is_last=0.
  - Byte with rx_last: go to PUSH_LAST with byte_num = count mod 4 after the byte. If byte_num=0 (length multiple of 4), first PUSH the full word with is_last=0, then PUSH_LAST with an empty word (k_in=0, byte_num=0).
  - rx_empty_msg: go directly to PUSH_LAST, byte_num=0, k_in=0.
  - rx_valid and rx_empty_msg in the same cycle: rx_valid wins; the pulse is ignored.
- PUSH / PUSH_LAST:
  - rx_ready=0. k_in_ready and k_is_last are asserted only in the cycle where k_buffer_full=0. A word is transferred exactly once, in that cycle.
  - Stall while k_buffer_full=1; k_in/k_byte_num are held stable.
  - k_is_last is never 1 while k_in_ready=0.
  - PUSH returns to COLLECT. PUSH_LAST goes to WAIT_HASH.
- WAIT_HASH: wait for k_out_ready=1, then SEND. No timeout.
- SEND:
  - Byte i = k_out[511-8i -: 8], i=0..63. tx_valid is held with stable data until tx_ready.
  - After byte 63 is accepted, go to CORE_RST.
- Bytes arriving while rx_ready=0 are the sender's responsibility (UART RX buffers them). The controller never drops an accepted byte.
- rst_n assertion mid-message aborts immediately. All state returns to reset values asynchronously; no partial digest is emitted.

Optional Feature:
- KECCAK_CTRL_HEX_OUT_EN defined:
  - SEND emits 128 ASCII lowercase hex characters, high nibble first ('0'-'9' = 0x30-0x39, 'a'-'f' = 0x61-0x66), followed by 0x0A (129 transfers).
- Undefined: 64 raw bytes; no terminator.

Decomposition:
- Package keccak_ctrl_pkg:
  - FSM state enum: CORE_RST, COLLECT, PUSH, PUSH_LAST, WAIT_HASH, SEND.
  - Constants DIGEST_BYTES=64, WORD_BYTES=4, HEX_LF=8'h0A.
- Sub-module keccak_word_packer: byte shift register plus mod-4 count. Outputs the word, full flag and byte_num; clears on k_reset.
- The FSM and digest serializer stay in keccak_ctrl.

Test Plan:
- Reset/startup: release rst_n → k_reset high for exactly 2 cycles, then rx_ready=1, busy=0.
- rx_empty_msg pulse → one core transfer, k_in=0, k_is_last=1, k_byte_num=0. Streamed 64 bytes match the golden model digest of the empty message.
- Message "abc" (0x61,0x62,0x63 with rx_last) → single transfer k_in=32'h61626300, is_last=1, byte_num=3. Digest matches golden model.
- Message "abcd" → transfers 32'h61626364 (is_last=0), then 32'h00000000 (is_last=1, byte_num=0).
- Backpressure: hold k_buffer_full=1 for 10 cycles during PUSH, and toggle tx_ready randomly during SEND → no k_in_ready while full, exactly one transfer per word, 64 bytes in order with none duplicated.
- Abort: assert rst_n low mid-SEND after byte 20 → tx_valid=0 immediately. A new "abc" message after reset produces the correct full digest.
